// File: rtl/logical_driver.sv
`timescale 1ns/1ps
// Sequential front end for the nibble logic unit: queues commands, drives sendi/sel, captures lu_out.
// Latency: accept-to-res_valid = SETTLE_CYCLES+1 edges. cmd_ready drops when the FIFO is full; HOLD stalls on res_ready.
// Optional LOGICAL_DRIVER_CHECK_EN builds a result checker driving the sticky err flag.

module logical_driver_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

module logical_driver #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_x,
    input  logic [3:0] cmd_y,
    input  logic [1:0] cmd_op,
    output logic [7:0] sendi,
    output logic [1:0] sel,
    input  logic [7:0] lu_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [1:0] res_op,
    output logic [7:0] done_count,
    output logic       err
);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] op;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    cmd_t             push_cmd;
    logic [$bits(cmd_t)-1:0] head_raw;
    cmd_t             head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             capture;

    assign push_cmd  = '{x: cmd_x, y: cmd_y, op: cmd_op};
    assign head      = cmd_t'(head_raw);
    assign cmd_ready = !fifo_full;
    assign capture   = (state == DRIVE) && (cnt == CNT_LAST);

    // A pop happens from IDLE, or in HOLD on the same edge the result is taken.
    assign pop = !fifo_empty && ((state == IDLE) || ((state == HOLD) && res_ready));

    logical_driver_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (cmd_valid),
        .push_dat (push_cmd),
        .pop      (pop),
        .pop_dat  (head_raw),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sendi      <= '0;
            sel        <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_op     <= '0;
            done_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        sendi <= {head.x, head.y};
                        sel   <= head.op;
                        cnt   <= '0;
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (capture) begin
                        res_data  <= lu_out;
                        res_op    <= sel;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid  <= 1'b0;
                        done_count <= done_count + 8'd1;
                        if (pop) begin
                            sendi <= {head.x, head.y};
                            sel   <= head.op;
                            cnt   <= '0;
                            state <= DRIVE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LOGICAL_DRIVER_CHECK_EN
    function automatic logic [7:0] expected_result(input logic [7:0] operands, input logic [1:0] op);
        logic [3:0] x;
        logic [3:0] y;
        x = operands[7:4];
        y = operands[3:0];
        case (op)
            2'b00:   expected_result = {4'b0, x & y};
            2'b01:   expected_result = {4'b0, x | y};
            2'b10:   expected_result = {4'b0, x ^ y};
            default: expected_result = ~operands;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (capture && (lu_out != expected_result(sendi, sel))) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_logical_driver.sv
`timescale 1ns/1ps
// Randomized self-checking bench for logical_driver: reference queue model of the command/result stream.
module tb_logical_driver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       cmd_valid = 1'b0, cmd_ready;
    logic [3:0] cmd_x = '0, cmd_y = '0;
    logic [1:0] cmd_op = '0;
    logic [7:0] sendi;
    logic [1:0] sel;
    logic [7:0] lu_out;
    logic       res_valid, res_ready = 1'b0;
    logic [7:0] res_data;
    logic [1:0] res_op;
    logic [7:0] done_count;
    logic       err;
    logic       lu_force_en = 1'b0;
    logic [7:0] lu_force = '0;

    logic       cmd_valid3 = 1'b0, cmd_ready3;
    logic [3:0] cmd_x3 = '0, cmd_y3 = '0;
    logic [1:0] cmd_op3 = '0;
    logic [7:0] sendi3;
    logic [1:0] sel3;
    logic [7:0] lu_out3;
    logic       res_valid3, res_ready3 = 1'b0;
    logic [7:0] res_data3;
    logic [1:0] res_op3;
    logic [7:0] done_count3;
    logic       err3;
    logic       lu_force_en3 = 1'b0;
    logic [7:0] lu_force3 = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hs_total = 0;
    logic last_acc;
    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];

`ifdef LOGICAL_DRIVER_CHECK_EN
    localparam logic ERR_EXPECTED = 1'b1;
`else
    localparam logic ERR_EXPECTED = 1'b0;
`endif

    // Behaviour of the combinational unit the driver feeds.
    function automatic logic [7:0] unit_fn(input logic [3:0] x, input logic [3:0] y, input logic [1:0] op);
        case (op)
            2'd0:    return {4'h0, x & y};
            2'd1:    return {4'h0, x | y};
            2'd2:    return {4'h0, x ^ y};
            default: return ~{x, y};
        endcase
    endfunction

    assign lu_out  = lu_force_en  ? lu_force  : unit_fn(sendi[7:4], sendi[3:0], sel);
    assign lu_out3 = lu_force_en3 ? lu_force3 : unit_fn(sendi3[7:4], sendi3[3:0], sel3);

    logical_driver #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_op(cmd_op), .sendi(sendi), .sel(sel),
        .lu_out(lu_out), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_op(res_op), .done_count(done_count), .err(err)
    );

    logical_driver #(.FIFO_DEPTH(4), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_x(cmd_x3), .cmd_y(cmd_y3), .cmd_op(cmd_op3), .sendi(sendi3), .sel(sel3),
        .lu_out(lu_out3), .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3),
        .res_op(res_op3), .done_count(done_count3), .err(err3)
    );

    always #5 clk = ~clk;

    // One clock edge on the main instance; records accepted commands and delivered results.
    task automatic step();
        logic acc, hs;
        logic [9:0] exp_e, obs_e;
        acc   = cmd_valid && cmd_ready;
        hs    = res_valid && res_ready;
        exp_e = {unit_fn(cmd_x, cmd_y, cmd_op), cmd_op};
        obs_e = {res_data, res_op};
        @(posedge clk);
        #1;
        cyc++;
        last_acc = acc;
        if (acc) exp_q.push_back(exp_e);
        if (hs) begin
            obs_q.push_back(obs_e);
            hs_total++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        checks++; if (sendi !== 8'h00)     begin errors++; $display("FAIL reset_sendi got=%h want=00", sendi); end
        checks++; if (sel !== 2'd0)        begin errors++; $display("FAIL reset_sel got=%h want=0", sel); end
        checks++; if (res_valid !== 1'b0)  begin errors++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
        checks++; if (res_data !== 8'h00)  begin errors++; $display("FAIL reset_res_data got=%h want=00", res_data); end
        checks++; if (res_op !== 2'd0)     begin errors++; $display("FAIL reset_res_op got=%h want=0", res_op); end
        checks++; if (done_count !== 8'h0) begin errors++; $display("FAIL reset_done_count got=%h want=00", done_count); end
        checks++; if (err !== 1'b0)        begin errors++; $display("FAIL reset_err got=%b want=0", err); end
        checks++; if (cmd_ready !== 1'b1)  begin errors++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    endtask

    task automatic test_ops();
        logic [7:0] want [4];
        int n;
        want[0] = 8'h08; want[1] = 8'h0E; want[2] = 8'h06; want[3] = 8'h53;
        res_ready = 1'b1;
        for (int op = 0; op < 4; op++) begin
            cmd_x = 4'hA; cmd_y = 4'hC; cmd_op = 2'(op); cmd_valid = 1'b1;
            step();
            cmd_valid = 1'b0;
            n = 0;
            while (!res_valid && n < 20) begin step(); n++; end
            checks++; if (n !== 2) begin errors++; $display("FAIL ops_latency op=%0d got=%0d want=2", op, n); end
            checks++; if (res_data !== want[op]) begin errors++; $display("FAIL ops_data op=%0d got=%h want=%h", op, res_data, want[op]); end
            checks++; if (res_op !== 2'(op)) begin errors++; $display("FAIL ops_res_op got=%0d want=%0d", res_op, op); end
            step();
            checks++; if (done_count !== 8'(op + 1)) begin errors++; $display("FAIL ops_done_count got=%0d want=%0d", done_count, op + 1); end
        end
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [9:0] cmds [6];
        int acc, n;
        exp_q.delete(); obs_q.delete();
        for (int i = 0; i < 6; i++) cmds[i] = 10'($urandom);
        res_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            cmd_valid = (acc < 6);
            {cmd_x, cmd_y, cmd_op} = cmds[acc < 6 ? acc : 5];
            step();
            if (last_acc) begin
                acc++;
                if (acc == 5) begin
                    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_full_after_5 got=%b want=0", cmd_ready); end
                end
            end
        end
        checks++; if (acc !== 5) begin errors++; $display("FAIL bp_accepts got=%0d want=5", acc); end
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_res_valid got=%b want=1", res_valid); end
        res_ready = 1'b1;
        step();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got=%b want=1", cmd_ready); end
        n = 0;
        while (obs_q.size() < 6 && n < 60) begin
            if (last_acc) acc++;
            cmd_valid = (acc < 6);
            step();
            n++;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        checks++; if (obs_q.size() !== 6) begin errors++; $display("FAIL bp_result_count got=%0d want=6", obs_q.size()); end
        for (int i = 0; i < 6 && i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_order idx=%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_settle();
        logic [3:0] x, y;
        logic [1:0] op;
        logic [7:0] v1, v2, v3;
        x = 4'($urandom); y = 4'($urandom); op = 2'($urandom);
        v1 = 8'($urandom); v2 = v1 ^ 8'hFF; v3 = v1 ^ 8'h5A;
        cmd_x3 = x; cmd_y3 = y; cmd_op3 = op; cmd_valid3 = 1'b1;
        res_ready3 = 1'b0;
        lu_force_en3 = 1'b1; lu_force3 = ~v3;
        step();
        cmd_valid3 = 1'b0;
        step();
        checks++; if ({sendi3, sel3} !== {x, y, op}) begin errors++; $display("FAIL settle_issue got=%h/%h want=%h/%h", sendi3, sel3, {x, y}, op); end
        lu_force3 = v1;
        step();
        lu_force3 = v2;
        checks++; if (res_valid3 !== 1'b0) begin errors++; $display("FAIL settle_early1 got=%b want=0", res_valid3); end
        step();
        lu_force3 = v3;
        checks++; if (res_valid3 !== 1'b0) begin errors++; $display("FAIL settle_early2 got=%b want=0", res_valid3); end
        checks++; if ({sendi3, sel3} !== {x, y, op}) begin errors++; $display("FAIL settle_drive_stable got=%h/%h want=%h/%h", sendi3, sel3, {x, y}, op); end
        step();
        lu_force3 = ~v3;
        checks++; if (res_valid3 !== 1'b1) begin errors++; $display("FAIL settle_valid got=%b want=1", res_valid3); end
        checks++; if (res_data3 !== v3) begin errors++; $display("FAIL settle_capture got=%h want=%h", res_data3, v3); end
        checks++; if (res_op3 !== op) begin errors++; $display("FAIL settle_res_op got=%h want=%h", res_op3, op); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({res_valid3, res_data3, sendi3, sel3} !== {1'b1, v3, x, y, op}) begin
                errors++; $display("FAIL settle_hold_stable cyc=%0d got=%b/%h/%h/%h want=1/%h/%h/%h", i, res_valid3, res_data3, sendi3, sel3, v3, {x, y}, op);
            end
        end
        res_ready3 = 1'b1;
        step();
        res_ready3 = 1'b0;
        lu_force_en3 = 1'b0;
        checks++; if (res_valid3 !== 1'b0) begin errors++; $display("FAIL settle_release got=%b want=0", res_valid3); end
        checks++; if (done_count3 !== 8'd1) begin errors++; $display("FAIL settle_done_count got=%0d want=1", done_count3); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] x1, y1;
        int highs;
        res_ready3 = 1'b0;
        x1 = 4'($urandom) | 4'h1; y1 = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
            cmd_x3 = (i == 0) ? x1 : 4'($urandom);
            cmd_y3 = (i == 0) ? y1 : 4'($urandom);
            cmd_op3 = 2'($urandom);
            cmd_valid3 = 1'b1;
            step();
        end
        cmd_valid3 = 1'b0;
        checks++; if ({res_valid3, sendi3} !== {1'b0, x1, y1}) begin errors++; $display("FAIL rmid_in_drive got=%b/%h want=0/%h", res_valid3, sendi3, {x1, y1}); end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({sendi3, sel3, res_valid3, res_data3, res_op3, done_count3, err3} !== '0) begin
            errors++; $display("FAIL rmid_outputs_zero got=%h/%h/%b/%h/%h/%h/%b want=all 0", sendi3, sel3, res_valid3, res_data3, res_op3, done_count3, err3);
        end
        step();
        rst_n = 1'b1;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (res_valid3) highs++;
        end
        checks++; if (highs !== 0) begin errors++; $display("FAIL rmid_no_result got=%0d want=0", highs); end
        checks++; if (cmd_ready3 !== 1'b1) begin errors++; $display("FAIL rmid_cmd_ready got=%b want=1", cmd_ready3); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        int acc, n, c_first, c_last, mism;
        logic seen255;
        exp_q.delete(); obs_q.delete();
        hs_total = 0; acc = 0; n = 0; c_first = 0; c_last = 0; seen255 = 1'b0;
        res_ready = 1'b1;
        while (hs_total < 256 && n < 3000) begin
            cmd_valid = (acc < 256);
            cmd_x = 4'($urandom); cmd_y = 4'($urandom); cmd_op = 2'($urandom);
            step();
            n++;
            if (last_acc) acc++;
            if (hs_total == 1 && c_first == 0) c_first = cyc;
            if (hs_total == 255 && !seen255) begin
                seen255 = 1'b1;
                checks++; if (done_count !== 8'hFF) begin errors++; $display("FAIL wrap_255 got=%h want=FF", done_count); end
            end
        end
        c_last = cyc;
        cmd_valid = 1'b0;
        checks++; if (hs_total !== 256) begin errors++; $display("FAIL wrap_timeout got=%0d want=256", hs_total); end
        checks++; if (done_count !== 8'h00) begin errors++; $display("FAIL wrap_256 got=%h want=00", done_count); end
        checks++; if (c_last - c_first !== 510) begin errors++; $display("FAIL b2b_throughput got=%0d want=510", c_last - c_first); end
        mism = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) mism++;
        checks++; if (mism !== 0) begin errors++; $display("FAIL b2b_data got=%0d mismatches want=0", mism); end
        step(); step();
        res_ready = 1'b0;
    endtask

    task automatic test_err();
        int n;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_before got=%b want=0", err); end
        res_ready = 1'b1;
        lu_force_en = 1'b1; lu_force = 8'hFF;
        cmd_x = 4'h1; cmd_y = 4'h1; cmd_op = 2'd0; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 20) begin step(); n++; end
        checks++; if (res_data !== 8'hFF) begin errors++; $display("FAIL err_forced_data got=%h want=FF", res_data); end
        checks++; if (err !== ERR_EXPECTED) begin errors++; $display("FAIL err_at_capture got=%b want=%b", err, ERR_EXPECTED); end
        lu_force_en = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            cmd_x = 4'($urandom); cmd_y = 4'($urandom); cmd_op = 2'($urandom); cmd_valid = 1'b1;
            step();
            cmd_valid = 1'b0;
            n = 0;
            while (!res_valid && n < 20) begin step(); n++; end
            checks++; if (res_data !== unit_fn(cmd_x, cmd_y, cmd_op)) begin errors++; $display("FAIL err_good_data got=%h want=%h", res_data, unit_fn(cmd_x, cmd_y, cmd_op)); end
            step();
            checks++; if (err !== ERR_EXPECTED) begin errors++; $display("FAIL err_sticky got=%b want=%b", err, ERR_EXPECTED); end
        end
        res_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared got=%b want=0", err); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_ops();
        test_backpressure();
        test_settle();
        test_reset_mid();
        test_back_to_back();
        test_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/logical_driver.md
# logical_driver

Sequential front end for the 4-function nibble logic unit. It accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO. It drives the unit's `sendi` and `sel` inputs from registers, waits a programmable settle time, then captures the unit's 8-bit `out` and returns it over a valid/ready result interface. It sits between the board-level command source (switch/key debouncer or test controller) and the combinational logic unit.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `SETTLE_CYCLES`, 1: cycles `sendi`/`sel` are held before capture; ≥1.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low. The design has one clock; reset is asynchronous and active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_x`  in  4  operand x (driven onto `sendi[7:4]`).
- `cmd_y`  in  4  operand y (driven onto `sendi[3:0]`).
- `cmd_op`  in  2  00 AND, 01 OR, 10 XOR, 11 NOT.
- `sendi`  out  8  registered `{x,y}` to logic unit.
- `sel`  out  2  registered opcode to logic unit.
- `lu_out`  in  8  logic unit result.
- `res_valid`  out  1  result held.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  8  captured result.
- `res_op`  out  2  opcode of captured result.
- `done_count`  out  8  completed result handshakes, wraps.
- `err`  out  1  sticky mismatch flag (see Configuration).

## Operation
- Reset values: `sendi`=0, `sel`=0, `res_valid`=0, `res_data`=0, `res_op`=0, `done_count`=0, `err`=0, FIFO empty, state IDLE. `cmd_ready`=1 while out of reset.
- Push: `cmd_valid && cmd_ready` writes `{cmd_x,cmd_y,cmd_op}` at the edge. `cmd_ready` = !full. There is no push while full.
- States:
  - IDLE: if the FIFO is non-empty, pop the head, load `sendi`/`sel`, clear the settle counter, go to DRIVE. Otherwise hold.
  - DRIVE: increment the counter each edge. When counter == `SETTLE_CYCLES`-1, capture `lu_out`→`res_data` and `sel`→`res_op`, set `res_valid`, go to HOLD.
  - HOLD: hold `res_valid`, `res_data` and `sendi`/`sel` stable until `res_ready`. On the handshake edge: clear `res_valid` and increment `done_count`. Then pop and issue the next entry in the same edge (→DRIVE) if the FIFO is non-empty; otherwise go to IDLE.
- `sendi`/`sel` change only on a pop edge. In IDLE they retain the last issued values.
- Push and pop may occur on the same edge at any occupancy except push-when-full. Occupancy is then unchanged.
- FIFO pointers are log2(`FIFO_DEPTH`)+1 bits. Full/empty are decided by MSB compare, and pointers wrap naturally.
- `done_count` wraps 255→0.
- Expected unit function: AND/OR/XOR give `{4'b0, x op y}`; NOT gives `~{x,y}`.
- Reset asserted mid-operation: all state returns to reset values immediately, queued commands are discarded, and no result is emitted.

## Timing
- A command accepted at edge E0 into an empty FIFO with the driver in IDLE is popped at E1. `res_valid` rises after edge E1+`SETTLE_CYCLES`.
- Accept-to-`res_valid` latency = `SETTLE_CYCLES`+1 edges.
- Back-to-back throughput (`res_ready` held high, FIFO non-empty) = one result per `SETTLE_CYCLES`+1 cycles.
- Capacity = `FIFO_DEPTH` queued + 1 in flight. With `res_ready`=0, `cmd_ready` falls after `FIFO_DEPTH`+1 accepts from empty.
- `cmd_ready` rises the cycle after a pop from a full FIFO.

## Configuration
- `LOGICAL_DRIVER_CHECK_EN` defined: at each capture edge, compute the expected result from the issued `sendi`/`sel`. If it differs from `lu_out`, set `err`. `err` stays set until reset.
- Not defined: the checker is absent and `err` is tied 0. All other behaviour is identical.

## Test plan
- Reset, then one command x=A, y=C for each op with `res_ready`=1. Required `res_data`: AND 08, OR 0E, XOR 06, NOT 53; `res_op` echoes the op; `res_valid` rises 2 edges after accept (`SETTLE_CYCLES`=1).
- `res_ready`=0, push 6 commands continuously from empty. `cmd_ready` falls after the 5th accept and the 6th is held off. Then raise `res_ready`: results return in order and `cmd_ready` rises one cycle after the first pop.
- `SETTLE_CYCLES`=3: change `lu_out` at issue+1 and issue+2. Required: the value present at issue+3 is captured, and `sendi`/`sel` are stable throughout DRIVE and HOLD.
- Assert `rst_n` low while in DRIVE with 3 entries queued. Required: all outputs return to 0 immediately, and no `res_valid` follows after release without new commands.
- Complete 256 handshakes. Required: `done_count` reads FF after 255 and 00 after 256.
- With `LOGICAL_DRIVER_CHECK_EN`: force `lu_out`=FF for AND of x=1, y=1. Required: `err` rises at capture and stays 1 through later correct results until reset. Without the macro, `err` stays 0.
